// File: rtl/hazard_if.sv
// Hazard-control bundle between the datapath (master) and hazard_ctrl (slave).
// Carries the per-stage register indices, miss/redirect status, stage stalls/flushes and forwarding selects.
interface hazard_if #(
  parameter int unsigned REG_AW = 5
);
  logic              instr_miss_f_i;
  logic [REG_AW-1:0] rs1_d_i;
  logic [REG_AW-1:0] rs2_d_i;
  logic [REG_AW-1:0] rs1_e_i;
  logic [REG_AW-1:0] rs2_e_i;
  logic [REG_AW-1:0] rd_e_i;
  logic [2:0]        result_src_e_i;
  logic [1:0]        pc_src_i;
  logic [1:0]        pc_src_reg_i;
  logic              instr_cache_rep_en_i;
  logic              mc_op_e_i;
  logic              mc_done_i;
  logic              mc_start_o;
  logic [REG_AW-1:0] rd_m_i;
  logic [REG_AW-1:0] rd_w_i;
  logic              reg_write_m_i;
  logic              reg_write_w_i;
  logic              data_miss_m_i;
  logic              stall_f_o;
  logic              stall_d_o;
  logic              stall_e_o;
  logic              stall_m_o;
  logic              stall_w_o;
  logic              flush_d_o;
  logic              flush_e_o;
  logic              flush_m_o;
  logic [1:0]        forward_a_e_o;
  logic [1:0]        forward_b_e_o;

  modport master (
    output instr_miss_f_i, rs1_d_i, rs2_d_i, rs1_e_i, rs2_e_i, rd_e_i, result_src_e_i,
           pc_src_i, pc_src_reg_i, instr_cache_rep_en_i, mc_op_e_i, mc_done_i,
           rd_m_i, rd_w_i, reg_write_m_i, reg_write_w_i, data_miss_m_i,
    input  mc_start_o, stall_f_o, stall_d_o, stall_e_o, stall_m_o, stall_w_o,
           flush_d_o, flush_e_o, flush_m_o, forward_a_e_o, forward_b_e_o
  );

  modport slave (
    input  instr_miss_f_i, rs1_d_i, rs2_d_i, rs1_e_i, rs2_e_i, rd_e_i, result_src_e_i,
           pc_src_i, pc_src_reg_i, instr_cache_rep_en_i, mc_op_e_i, mc_done_i,
           rd_m_i, rd_w_i, reg_write_m_i, reg_write_w_i, data_miss_m_i,
    output mc_start_o, stall_f_o, stall_d_o, stall_e_o, stall_m_o, stall_w_o,
           flush_d_o, flush_e_o, flush_m_o, forward_a_e_o, forward_b_e_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use stall, D-cache miss freeze and multi-cycle execute sequencing.
// Optional HAZARD_PERF_CNT_EN adds a saturating stall_d cycle counter on stall_cnt_o.
module hazard_ctrl #(
  parameter int unsigned REG_AW          = 5,
  parameter logic [2:0]  RESULT_MEM_DATA = 3'b001
`ifdef HAZARD_PERF_CNT_EN
  ,
  parameter int unsigned PERF_W          = 32
`endif
) (
  input  logic   clk_i,
  input  logic   reset_n_i,
  hazard_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] stall_cnt_o
`endif
);

  typedef enum logic [1:0] {RUN, MC_WAIT, MC_HOLD} state_e;

  state_e state_q;

  logic op_e;
  logic dmiss;
  logic ext_stall;
  logic load_stall;
  logic mc_busy;
  logic mc_hold;
  logic mc_start;
  logic stall_w, stall_e, stall_d;

  // MEM result wins over WB; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                         input logic [REG_AW-1:0] rd_m, input logic wr_m,
                                         input logic [REG_AW-1:0] rd_w, input logic wr_w);
    logic [1:0] sel;
    sel = 2'b00;
    if (rs != REG_AW'(0)) begin
      if (wr_m && (rs == rd_m))      sel = 2'b10;
      else if (wr_w && (rs == rd_w)) sel = 2'b01;
    end
    return sel;
  endfunction

  // Reset masks the multi-cycle request so no start or busy stall escapes during reset.
  assign op_e       = hz.mc_op_e_i & reset_n_i;
  assign dmiss      = hz.data_miss_m_i;
  assign ext_stall  = hz.instr_miss_f_i | dmiss;
  assign load_stall = (hz.result_src_e_i == RESULT_MEM_DATA) && (hz.rd_e_i != REG_AW'(0)) &&
                      ((hz.rs1_d_i == hz.rd_e_i) || (hz.rs2_d_i == hz.rd_e_i));
  assign mc_busy    = ((state_q == RUN) & op_e & ~hz.mc_done_i) |
                      ((state_q == MC_WAIT) & ~hz.mc_done_i);
  assign mc_hold    = (state_q == MC_HOLD);
  assign mc_start   = (state_q == RUN) & op_e & ~dmiss;

  assign stall_w = ext_stall;
  assign stall_e = stall_w | mc_busy | (mc_hold & ext_stall);
  assign stall_d = stall_e | load_stall;

  assign hz.stall_w_o  = stall_w;
  assign hz.stall_m_o  = stall_w;
  assign hz.stall_e_o  = stall_e;
  assign hz.stall_d_o  = stall_d;
  assign hz.stall_f_o  = stall_d & ~hz.pc_src_reg_i[1];
  assign hz.flush_d_o  = hz.pc_src_i[1] & ~stall_e;
  assign hz.flush_e_o  = ((hz.pc_src_i[1] & (hz.instr_cache_rep_en_i | hz.pc_src_reg_i[1])) |
                          load_stall) & ~stall_e;
  assign hz.flush_m_o  = stall_e & ~stall_w;
  assign hz.mc_start_o = mc_start;

  assign hz.forward_a_e_o = fwd_sel(hz.rs1_e_i, hz.rd_m_i, hz.reg_write_m_i, hz.rd_w_i, hz.reg_write_w_i);
  assign hz.forward_b_e_o = fwd_sel(hz.rs2_e_i, hz.rd_m_i, hz.reg_write_m_i, hz.rd_w_i, hz.reg_write_w_i);

  logic unused_pc_lsb;
  assign unused_pc_lsb = ^{hz.pc_src_i[0], hz.pc_src_reg_i[0]};

  // Multi-cycle sequencer; a result that lands under an external stall is parked in MC_HOLD.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= RUN;
    end else begin
      unique case (state_q)
        RUN:     if (mc_start) state_q <= MC_WAIT;
        MC_WAIT: if (hz.mc_done_i) state_q <= ext_stall ? MC_HOLD : RUN;
        MC_HOLD: if (!ext_stall) state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q <= '0;
    end else if (stall_d && (cnt_q != '1)) begin
      cnt_q <= cnt_q + PERF_W'(1);
    end
  end

  assign stall_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios then random traffic, checked every cycle against a flag-based reference model.
module tb_hazard_ctrl;
  localparam logic [2:0] MEM_DATA = 3'b001;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  hazard_if #(.REG_AW(5)) hz ();

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt;
  hazard_ctrl dut (.clk_i(clk), .reset_n_i(rst_n), .hz(hz), .stall_cnt_o(stall_cnt));
`else
  hazard_ctrl dut (.clk_i(clk), .reset_n_i(rst_n), .hz(hz));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: an op has been launched and awaits its result / a result is parked behind a miss.
  bit          op_outstanding;
  bit          result_parked;
  logic [31:0] cnt_model;

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    assert (act === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (rs == 5'd0) return 2'b00;
    if (hz.reg_write_m_i && rs == hz.rd_m_i) return 2'b10;
    if (hz.reg_write_w_i && rs == hz.rd_w_i) return 2'b01;
    return 2'b00;
  endfunction

  task automatic cycle();
    bit idle, op, done, imiss, dm, ext, load, busy;
    bit sw, se, sd, sf, fd, fe, fm, start;
    @(negedge clk);
    if (!rst_n) begin
      op_outstanding = 0;
      result_parked  = 0;
      cnt_model      = 32'd0;
    end
    idle  = !op_outstanding && !result_parked;
    op    = hz.mc_op_e_i && rst_n;
    done  = hz.mc_done_i;
    imiss = hz.instr_miss_f_i;
    dm    = hz.data_miss_m_i;
    ext   = imiss || dm;
    load  = (hz.result_src_e_i == MEM_DATA) && (hz.rd_e_i != 5'd0) &&
            (hz.rs1_d_i == hz.rd_e_i || hz.rs2_d_i == hz.rd_e_i);
    busy  = (idle && op && !done) || (op_outstanding && !done);
    sw    = ext;
    se    = sw || busy || (result_parked && ext);
    sd    = se || load;
    sf    = sd && !hz.pc_src_reg_i[1];
    fd    = hz.pc_src_i[1] && !se;
    fe    = ((hz.pc_src_i[1] && (hz.instr_cache_rep_en_i || hz.pc_src_reg_i[1])) || load) && !se;
    fm    = se && !sw;
    start = idle && op && !dm;

    chk("stalls", 8'({hz.stall_f_o, hz.stall_d_o, hz.stall_e_o, hz.stall_m_o, hz.stall_w_o}),
        8'({sf, sd, se, sw, sw}));
    chk("flushes", 8'({hz.flush_d_o, hz.flush_e_o, hz.flush_m_o}), 8'({fd, fe, fm}));
    chk("fwd_a", 8'(hz.forward_a_e_o), 8'(ref_fwd(hz.rs1_e_i)));
    chk("fwd_b", 8'(hz.forward_b_e_o), 8'(ref_fwd(hz.rs2_e_i)));
    chk("mc_start", 8'(hz.mc_start_o), 8'(start));
`ifdef HAZARD_PERF_CNT_EN
    tests++;
    assert (stall_cnt === cnt_model) else begin
      fails++;
      $error("FAIL stall_cnt: got %0d expected %0d", stall_cnt, cnt_model);
    end
`endif

    @(posedge clk);
    if (!rst_n) begin
      op_outstanding = 0;
      result_parked  = 0;
      cnt_model      = 32'd0;
    end else begin
      if (sd && cnt_model != 32'hFFFF_FFFF) cnt_model++;
      if (result_parked) result_parked = ext;
      else if (op_outstanding) begin
        if (done) begin
          op_outstanding = 0;
          result_parked  = ext;
        end
      end else if (start) op_outstanding = 1;
    end
    #1;
  endtask

  task automatic quiet();
    hz.instr_miss_f_i       = 0;
    hz.rs1_d_i              = 5'd1;
    hz.rs2_d_i              = 5'd2;
    hz.rs1_e_i              = 5'd3;
    hz.rs2_e_i              = 5'd4;
    hz.rd_e_i               = 5'd9;
    hz.result_src_e_i       = 3'b000;
    hz.pc_src_i             = 2'b00;
    hz.pc_src_reg_i         = 2'b00;
    hz.instr_cache_rep_en_i = 0;
    hz.mc_op_e_i            = 0;
    hz.mc_done_i            = 0;
    hz.rd_m_i               = 5'd10;
    hz.rd_w_i               = 5'd11;
    hz.reg_write_m_i        = 0;
    hz.reg_write_w_i        = 0;
    hz.data_miss_m_i        = 0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    op_outstanding = 0;
    result_parked  = 0;
    cnt_model      = 32'd0;
    rst_n = 0;
    quiet();
    hz.mc_op_e_i = 1;
    cycle();
    cycle();
    hz.mc_op_e_i = 0;
    rst_n = 1;
    cycle();

    // Load-use on x5, then one clean cycle, then load to x0.
    hz.result_src_e_i = MEM_DATA; hz.rd_e_i = 5'd5; hz.rs1_d_i = 5'd5;
    cycle();
    hz.result_src_e_i = 3'b000;
    cycle();
    hz.result_src_e_i = MEM_DATA; hz.rd_e_i = 5'd0; hz.rs1_d_i = 5'd0;
    cycle();
    quiet();

    // Forwarding priority.
    hz.rs1_e_i = 5'd7; hz.rs2_e_i = 5'd7; hz.rd_m_i = 5'd7; hz.rd_w_i = 5'd7;
    hz.reg_write_m_i = 1; hz.reg_write_w_i = 1;
    cycle();
    hz.reg_write_m_i = 0;
    cycle();
    hz.rs1_e_i = 5'd0;
    cycle();
    quiet();

    // Multi-cycle op with done four cycles after start.
    hz.mc_op_e_i = 1;
    repeat (4) cycle();
    hz.mc_done_i = 1;
    cycle();
    hz.mc_op_e_i = 0; hz.mc_done_i = 0;
    cycle();

    // Result lands during a 3-cycle I-miss.
    hz.mc_op_e_i = 1;
    repeat (3) cycle();
    hz.mc_done_i = 1; hz.instr_miss_f_i = 1;
    cycle();
    hz.mc_done_i = 0;
    repeat (2) cycle();
    hz.instr_miss_f_i = 0;
    cycle();
    hz.mc_op_e_i = 0;
    cycle();

    // D-miss blocks the start for 5 cycles.
    hz.mc_op_e_i = 1; hz.data_miss_m_i = 1;
    repeat (5) cycle();
    hz.data_miss_m_i = 0;
    repeat (2) cycle();
    hz.mc_done_i = 1;
    cycle();
    quiet();
    cycle();

    // Redirect on top of a load-use stall.
    hz.pc_src_i = 2'b10; hz.pc_src_reg_i = 2'b10;
    hz.result_src_e_i = MEM_DATA; hz.rd_e_i = 5'd6; hz.rs2_d_i = 5'd6;
    cycle();
    quiet();

    // Reset while waiting on a multi-cycle result.
    hz.mc_op_e_i = 1;
    repeat (2) cycle();
    rst_n = 0;
    cycle();
    hz.mc_op_e_i = 0;
    rst_n = 1;
    cycle();
    hz.mc_done_i = 1;
    cycle();
    quiet();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      hz.instr_miss_f_i       = ($urandom_range(0, 5) == 0);
      hz.data_miss_m_i        = ($urandom_range(0, 5) == 0);
      hz.rs1_d_i              = 5'($urandom_range(0, 3));
      hz.rs2_d_i              = 5'($urandom_range(0, 3));
      hz.rs1_e_i              = 5'($urandom_range(0, 3));
      hz.rs2_e_i              = 5'($urandom_range(0, 3));
      hz.rd_e_i               = 5'($urandom_range(0, 3));
      hz.rd_m_i               = 5'($urandom_range(0, 3));
      hz.rd_w_i               = 5'($urandom_range(0, 3));
      hz.result_src_e_i       = ($urandom_range(0, 1) == 0) ? MEM_DATA : 3'($urandom_range(0, 7));
      hz.pc_src_i             = 2'($urandom_range(0, 3));
      hz.pc_src_reg_i         = 2'($urandom_range(0, 3));
      hz.instr_cache_rep_en_i = $urandom_range(0, 1) == 1;
      hz.reg_write_m_i        = $urandom_range(0, 1) == 1;
      hz.reg_write_w_i        = $urandom_range(0, 1) == 1;
      hz.mc_op_e_i            = $urandom_range(0, 1) == 1;
      hz.mc_done_i            = ($urandom_range(0, 3) == 0);
      rst_n                   = ($urandom_range(0, 60) != 0);
      cycle();
    end
    rst_n = 1;
    quiet();
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
